// File: rtl/round_sequencer_pkg.sv
// Shared definitions for the memory-game round controller: state codes,
// one-hot note constants and note-sequence helpers.
package round_sequencer_pkg;

  localparam int unsigned NOTE_W  = 4;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned SEQ_W   = NOTE_W * MAX_LEN;
  localparam int unsigned IDX_W   = 4;

  localparam logic [NOTE_W-1:0] NOTE_0 = 4'b0001;
  localparam logic [NOTE_W-1:0] NOTE_1 = 4'b0010;
  localparam logic [NOTE_W-1:0] NOTE_2 = 4'b0100;
  localparam logic [NOTE_W-1:0] NOTE_3 = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_LOAD         = 4'd1,
    ST_PLAY_ON      = 4'd2,
    ST_PLAY_GAP     = 4'd3,
    ST_WAIT_KEY     = 4'd4,
    ST_WAIT_RELEASE = 4'd5,
    ST_WON          = 4'd6,
    ST_LOST         = 4'd7,
    ST_GAME_OVER    = 4'd8
  } state_t;

  // Note idx lives in the idx-th nibble counted from the MSB end.
  function automatic logic [NOTE_W-1:0] note_at(input logic [SEQ_W-1:0] seq,
                                                input logic [IDX_W-1:0] idx);
    logic [SEQ_W-1:0] shifted;
    shifted = seq << {idx, 2'b00};
    return shifted[SEQ_W-1 -: NOTE_W];
  endfunction

  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] len);
    return (len > IDX_W'(MAX_LEN)) ? IDX_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/round_sequencer_cycle_timer.sv
// Loadable down-counter shared by the note, gap and key-timeout phases.
module round_sequencer_cycle_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/round_sequencer.sv
// Round-level controller: plays a latched note sequence, checks the player's
// responses with a per-note timeout, and tracks lives and score.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned LIVES          = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEQ_W-1:0]  level_data,
  input  logic [IDX_W-1:0]  level_length,
  input  logic [NOTE_W-1:0] note_inputs,
  output logic [NOTE_W-1:0] note_outputs,
  output logic              busy,
  output logic              round_won,
  output logic              round_lost,
  output logic [1:0]        lives,
  output logic [7:0]        score,
  output logic [3:0]        state_code
);

  localparam int unsigned TW = 32;

  state_t             state;
  state_t             next_c;
  logic [SEQ_W-1:0]   seq_q;
  logic [IDX_W-1:0]   len_q;
  logic [IDX_W-1:0]   index;
  logic               replay;

  logic [SEQ_W-1:0]   load_seq_c;
  logic [IDX_W-1:0]   load_len_c;
  logic [IDX_W-1:0]   idx_inc_c;
  logic [NOTE_W-1:0]  note_c;
  logic               tmr_load_c;
  logic               tmr_enable_c;
  logic [TW-1:0]      tmr_value_c;
  logic               expired;

  // A replay after a loss reuses the latched level instead of the live inputs.
  always_comb begin
    next_c     = state;
    load_seq_c = replay ? seq_q : level_data;
    load_len_c = replay ? len_q : clamp_len(level_length);
    note_c     = note_at(seq_q, index);
    idx_inc_c  = index + IDX_W'(1);
    case (state)
      ST_IDLE:         if (start) next_c = ST_LOAD;
      ST_LOAD:         next_c = (load_len_c == '0) ? ST_WON : ST_PLAY_ON;
      ST_PLAY_ON:      if (expired) next_c = ST_PLAY_GAP;
      ST_PLAY_GAP: begin
        if (expired) next_c = (index == len_q - IDX_W'(1)) ? ST_WAIT_KEY : ST_PLAY_ON;
      end
      ST_WAIT_KEY: begin
        if (note_inputs != '0) next_c = (note_inputs == note_c) ? ST_WAIT_RELEASE : ST_LOST;
        else if (expired)      next_c = ST_LOST;
      end
      ST_WAIT_RELEASE: begin
        if (note_inputs == '0) next_c = (idx_inc_c == len_q) ? ST_WON : ST_WAIT_KEY;
      end
      ST_WON:          next_c = ST_IDLE;
      ST_LOST:         next_c = (lives == 2'd1) ? ST_GAME_OVER : ST_LOAD;
      ST_GAME_OVER:    next_c = ST_GAME_OVER;
      default:         next_c = ST_IDLE;
    endcase
  end

  // Timer reloads on every state change with the new phase length minus one.
  always_comb begin
    tmr_value_c = '0;
    case (next_c)
      ST_PLAY_ON:  tmr_value_c = TW'(NOTE_CYCLES - 1);
      ST_PLAY_GAP: tmr_value_c = TW'(GAP_CYCLES - 1);
      ST_WAIT_KEY: tmr_value_c = TW'(TIMEOUT_CYCLES - 1);
      default:     tmr_value_c = '0;
    endcase
  end

  assign tmr_load_c   = (next_c != state);
  assign tmr_enable_c = (state == ST_PLAY_ON) || (state == ST_PLAY_GAP) ||
                        (state == ST_WAIT_KEY);

  round_sequencer_cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load_c),
    .load_value (tmr_value_c),
    .enable     (tmr_enable_c),
    .expired    (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      seq_q      <= '0;
      len_q      <= '0;
      index      <= '0;
      replay     <= 1'b0;
      lives      <= 2'(LIVES);
      score      <= '0;
      round_won  <= 1'b0;
      round_lost <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_c;
      round_won  <= (next_c == ST_WON);
      round_lost <= (next_c == ST_LOST);
      busy       <= (next_c != ST_IDLE) && (next_c != ST_GAME_OVER);
      case (state)
        ST_IDLE: replay <= 1'b0;
        ST_LOAD: begin
          seq_q <= load_seq_c;
          len_q <= load_len_c;
          index <= '0;
        end
        ST_PLAY_GAP: begin
          if (expired) index <= (next_c == ST_WAIT_KEY) ? '0 : idx_inc_c;
        end
        ST_WAIT_RELEASE: begin
          if (note_inputs == '0) index <= idx_inc_c;
        end
        ST_WON: begin
          if (score != 8'hFF) score <= score + 8'd1;
        end
        ST_LOST: begin
          lives  <= lives - 2'd1;
          replay <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // LEDs show the current note while playing and echo the keys while answering.
  always_comb begin
    note_outputs = '0;
    case (state)
      ST_PLAY_ON:                   note_outputs = note_c;
      ST_WAIT_KEY, ST_WAIT_RELEASE: note_outputs = note_inputs;
      default:                      note_outputs = '0;
    endcase
  end

  assign state_code = state;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Round-level controller for the memory game. It latches one level's note sequence and plays it on the LEDs with timed note-on and gap phases. It then checks the player's key responses note by note, with a per-note timeout. It also tracks lives and score, and reports round outcome pulses to the top-level game FSM and the hex display.

Parameters:
NOTE_CYCLES, 4, clock cycles each note is lit (25000000 on board)
GAP_CYCLES, 2, dark cycles after each note, must be >= 1
TIMEOUT_CYCLES, 16, cycles allowed in WAIT_KEY before a forced loss
MAX_LEN, 8, maximum notes per level (nibbles in level_data)
LIVES, 3, lives at reset, range 1..3

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset; one clock; sampled on rising edge of clk
start  in  1  begin round; honoured only in IDLE
level_data  in  32  note i at bits [31-4i:28-4i], one-hot
level_length  in  4  number of notes in the level
note_inputs  in  4  active-high key presses, already debounced
note_outputs  out  4  LED drive
busy  out  1  high in every state except IDLE and GAME_OVER
round_won  out  1  one-cycle pulse
round_lost  out  1  one-cycle pulse
lives  out  2  remaining lives
score  out  8  rounds won, saturating
state_code  out  4  current state encoding, for the hex decoder

Behaviour:
- State encoding: IDLE=0, LOAD=1, PLAY_ON=2, PLAY_GAP=3, WAIT_KEY=4, WAIT_RELEASE=5, WON=6, LOST=7, GAME_OVER=8. Each of WON and LOST lasts exactly one cycle.
- Reset values:
  - state IDLE; lives=LIVES; score=0.
  - index=0, timer=0, sequence latch=0.
  - round_won=0, round_lost=0.
- IDLE: start=1 -> LOAD on the next edge. start is ignored in every other state.
- LOAD (1 cycle):
  - Snapshot level_data and length into internal registers; later input changes are ignored until the next LOAD.
  - Length is clamped to MAX_LEN if larger.
  - Length 0 -> WON; otherwise -> PLAY_ON with index=0.
- PLAY_ON:
  - note_outputs = latched note[index] for exactly NOTE_CYCLES cycles.
  - Then -> PLAY_GAP.
- PLAY_GAP:
  - note_outputs = 0 for exactly GAP_CYCLES cycles.
  - If index = length-1 -> WAIT_KEY with index=0; else index+1 -> PLAY_ON.
- Timer: one shared down-counter, reloaded on every state entry (phase length minus 1); the state transitions when it reaches 0. Each WAIT_KEY entry reloads TIMEOUT_CYCLES, so the timeout is per note.
- WAIT_KEY: note_outputs echoes note_inputs.
  - If note_inputs == 0 for TIMEOUT_CYCLES cycles -> LOST.
  - On the first cycle with note_inputs != 0, compare it with note[index] exactly:
    - equal -> WAIT_RELEASE;
    - unequal -> LOST. A multi-key press is never one-hot, so it always loses.
- WAIT_RELEASE: note_outputs echoes note_inputs.
  - Wait for note_inputs == 0, with no timeout.
  - Then index+1; if the new index equals length -> WON, else -> WAIT_KEY.
- WON:
  - round_won=1 for this cycle; score increments, saturating at 255.
  - -> IDLE.
- LOST:
  - round_lost=1 for this cycle; lives decrements.
  - New lives = 0 -> GAME_OVER; else -> LOAD, which replays from the latched level_data (not re-sampled).
- GAME_OVER: sticky until reset; note_outputs=0.
- note_outputs in IDLE, LOAD, PLAY_GAP, WON, LOST and GAME_OVER is 0. The output is combinational from state and registers.
- Latency: start high at edge t gives LOAD at t+1, note 0 lit over edges t+2 .. t+1+NOTE_CYCLES.
- Reset asserted mid-round overrides all activity: the next state is IDLE with the reset values above. Outcome pulses for that cycle are suppressed.

Decomposition:
- Shared game package/include holds:
  - state localparams (codes above, also consumed by the hex display);
  - note one-hot constants NOTE_0..NOTE_3;
  - note slice width 4 and MAX_LEN.
- One natural sub-module: cycle_timer. Inputs: clk, reset, load, load_value, enable. Output: expired (count == 0). It is instantiated once for the shared phase and timeout counter.

Test Plan:
- Correct round:
  - Stimulus: level_data=0x1248_0000, length=4, start pulse.
  - Response: note_outputs shows 1,2,4,8, each for 4 cycles with 2-cycle gaps.
  - Player presses 1,2,4,8 with releases -> round_won pulse, score=1, state IDLE.
- Wrong key:
  - Stimulus: same level, player presses 2 when 1 is expected.
  - Response: round_lost pulse, lives 3->2, LOAD then replay of note 0.
- Timeout:
  - Stimulus: no key for 16 cycles in WAIT_KEY.
  - Response: round_lost on the 17th cycle; three consecutive losses -> lives=0, GAME_OVER, start ignored, busy=0.
- Multi-key and clamp:
  - Stimulus A: keys 0011 pressed when note 0001 is expected -> LOST.
  - Stimulus B: length=12 -> exactly 8 notes played.
  - Stimulus C: length=0 -> WON pulse two cycles after start.
- Snapshot and reset:
  - Stimulus A: change level_data during PLAY_ON -> playback unchanged.
  - Stimulus B: assert reset in WAIT_RELEASE -> next cycle IDLE, lives=3, score=0, no pulses.
- Score saturation:
  - Stimulus: force score=255, then win a round.
  - Response: score stays 255, round_won still pulses.
